// File: rtl/sata_reg_fis_transmitter.sv
// Host-to-Device Register FIS transmitter: captures one ATA command, sends it as a 5-dword FIS, retries on R_ERR.
// Latency: capture -> first dword 1 cycle; 5 cycles per FIS at full rate; status -> result pulse 1 cycle.
// Backpressure: o_rdy low holds the current dword stable; i_rdy is high only in IDLE, so commands wait upstream.
module sata_reg_fis_transmitter #(
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  i_dat_command,
  input  logic [15:0] i_dat_features,
  input  logic [47:0] i_dat_address,
  input  logic [7:0]  i_dat_device,
  input  logic [15:0] i_dat_scount,
  input  logic [7:0]  i_dat_control,
  input  logic        i_val,
  output logic        i_rdy,
  output logic [31:0] o_dat,
  output logic        o_val,
  output logic        o_eop,
  input  logic        o_rdy,
  input  logic        i_stat_val,
  input  logic        i_stat_err,
  output logic        o_res_val,
  output logic        o_res_err
);

  localparam logic [3:0] MAX_R   = 4'(MAX_RETRY);
  localparam logic [7:0] FIS_H2D = 8'h27;  // Register FIS, host to device
  localparam logic [7:0] FLAG_C  = 8'h80;  // C=1 (command register update), PM port 0
  localparam logic [2:0] LAST_DW = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RES
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  retry_q, retry_d;
  logic        res_err_q, res_err_d;

  // Captured command; replayed verbatim on every retransmission.
  logic [7:0]  cmd_q;
  logic [15:0] feat_q;
  logic [47:0] addr_q;
  logic [7:0]  dev_q;
  logic [15:0] scnt_q;
  logic [7:0]  ctl_q;

  logic        capture;
  logic [31:0] dw_sel;

  assign capture = (state_q == S_IDLE) && i_val;

  // State, dword index, retry count and result flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      retry_q   <= '0;
      res_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      res_err_q <= res_err_d;
    end
  end

  // Command field capture, only while idle so later input changes are invisible.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q  <= '0;
      feat_q <= '0;
      addr_q <= '0;
      dev_q  <= '0;
      scnt_q <= '0;
      ctl_q  <= '0;
    end else if (capture) begin
      cmd_q  <= i_dat_command;
      feat_q <= i_dat_features;
      addr_q <= i_dat_address;
      dev_q  <= i_dat_device;
      scnt_q <= i_dat_scount;
      ctl_q  <= i_dat_control;
    end
  end

  // FIS dword selection from the captured fields.
  always_comb begin
    dw_sel = '0;
    case (idx_q)
      3'd0:    dw_sel = {feat_q[7:0], cmd_q, FLAG_C, FIS_H2D};
      3'd1:    dw_sel = {dev_q, addr_q[23:0]};
      3'd2:    dw_sel = {feat_q[15:8], addr_q[47:24]};
      3'd3:    dw_sel = {ctl_q, 8'h00, scnt_q};
      default: dw_sel = '0;
    endcase
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    res_err_d = res_err_q;
    i_rdy     = 1'b0;
    o_val     = 1'b0;
    o_eop     = 1'b0;
    o_dat     = '0;
    o_res_val = 1'b0;
    o_res_err = 1'b0;

    case (state_q)
      S_IDLE: begin
        i_rdy = 1'b1;
        if (i_val) begin
          idx_d     = '0;
          retry_d   = '0;
          res_err_d = 1'b0;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        o_val = 1'b1;
        o_dat = dw_sel;
        o_eop = (idx_q == LAST_DW);
        if (o_rdy) begin
          if (idx_q == LAST_DW) begin
            idx_d   = '0;
            state_d = S_WAIT;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      S_WAIT: begin
        if (i_stat_val) begin
          if (!i_stat_err) begin
            res_err_d = 1'b0;
            state_d   = S_RES;
          end else if (retry_q < MAX_R) begin
            retry_d = retry_q + 4'd1;
            idx_d   = '0;
            state_d = S_SEND;
          end else begin
            res_err_d = 1'b1;
            state_d   = S_RES;
          end
        end
      end

      S_RES: begin
        o_res_val = 1'b1;
        o_res_err = res_err_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sata_reg_fis_transmitter.sv
// Bench for the Register FIS transmitter: table of commands with hand-computed dwords,
// scoreboard queues for dwords and results, plus hand sequences for stall, ignored
// inputs, early status and mid-frame reset. A MAX_RETRY=0 copy shares all inputs.
module tb_sata_reg_fis_transmitter;

  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_dat_command;
  logic [15:0] i_dat_features;
  logic [47:0] i_dat_address;
  logic [7:0]  i_dat_device;
  logic [15:0] i_dat_scount;
  logic [7:0]  i_dat_control;
  logic        i_val;
  logic        i_rdy;
  logic [31:0] o_dat;
  logic        o_val;
  logic        o_eop;
  logic        o_rdy;
  logic        i_stat_val;
  logic        i_stat_err;
  logic        o_res_val;
  logic        o_res_err;

  logic        r0_rdy, r0_val, r0_eop, r0_res_val, r0_res_err;
  logic [31:0] r0_dat;

  always #5 clk = ~clk;

  sata_reg_fis_transmitter #(.MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset),
    .i_dat_command(i_dat_command), .i_dat_features(i_dat_features),
    .i_dat_address(i_dat_address), .i_dat_device(i_dat_device),
    .i_dat_scount(i_dat_scount), .i_dat_control(i_dat_control),
    .i_val(i_val), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy),
    .i_stat_val(i_stat_val), .i_stat_err(i_stat_err),
    .o_res_val(o_res_val), .o_res_err(o_res_err)
  );

  sata_reg_fis_transmitter #(.MAX_RETRY(0)) dut0 (
    .clk(clk), .reset(reset),
    .i_dat_command(i_dat_command), .i_dat_features(i_dat_features),
    .i_dat_address(i_dat_address), .i_dat_device(i_dat_device),
    .i_dat_scount(i_dat_scount), .i_dat_control(i_dat_control),
    .i_val(i_val), .i_rdy(r0_rdy),
    .o_dat(r0_dat), .o_val(r0_val), .o_eop(r0_eop), .o_rdy(o_rdy),
    .i_stat_val(i_stat_val), .i_stat_err(i_stat_err),
    .o_res_val(r0_res_val), .o_res_err(r0_res_err)
  );

  typedef struct {
    logic [7:0]       cmd;
    logic [15:0]      feat;
    logic [47:0]      addr;
    logic [7:0]       dev;
    logic [15:0]      scnt;
    logic [7:0]       ctl;
    int               n_err;   // R_ERR statuses before OK; > MAXR means never OK
    bit               bp;      // random o_rdy backpressure
    logic [4:0][31:0] dw;      // expected dwords, dw[0] first
    logic             res_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        eop;
  } exp_t;

  exp_t exp_q[$];
  logic res_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   done_target = 0;
  int   res_seen = 0;
  bit   rand_bp = 0;
  vec_t vecs[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] cmd, input logic [15:0] feat,
                              input logic [47:0] addr, input logic [7:0] dev,
                              input logic [15:0] scnt, input logic [7:0] ctl,
                              input int n_err, input bit bp,
                              input logic [4:0][31:0] dw, input logic res_err);
    vec_t v;
    v.cmd = cmd; v.feat = feat; v.addr = addr; v.dev = dev; v.scnt = scnt; v.ctl = ctl;
    v.n_err = n_err; v.bp = bp; v.dw = dw; v.res_err = res_err;
    return v;
  endfunction

  function automatic int attempts(input int n_err);
    return (n_err > MAXR) ? MAXR + 1 : n_err + 1;
  endfunction

  // Random backpressure source.
  always @(posedge clk) begin
    #1;
    if (rand_bp) o_rdy = 1'($urandom_range(0, 1));
  end

  // Scoreboard: dwords accepted by the link and result pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (o_val && o_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dword", {32'h0, o_dat}, 64'hDEAD);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("dword", {32'h0, o_dat}, {32'h0, e.dat});
          chk("eop", {63'h0, o_eop}, {63'h0, e.eop});
          if (o_eop) done_cnt++;
        end
      end
      if (o_res_val) begin
        res_seen++;
        if (res_q.size() == 0) begin
          chk("unexpected_result", 64'h1, 64'h0);
        end else begin
          logic r;
          r = res_q.pop_front();
          chk("res_err", {63'h0, o_res_err}, {63'h0, r});
        end
      end
    end
  end

  task automatic drive_fields(input vec_t v);
    i_dat_command  = v.cmd;
    i_dat_features = v.feat;
    i_dat_address  = v.addr;
    i_dat_device   = v.dev;
    i_dat_scount   = v.scnt;
    i_dat_control  = v.ctl;
  endtask

  task automatic send_cmd(input vec_t v);
    int n = 0;
    while (!i_rdy && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("i_rdy_wait", {63'h0, i_rdy}, 64'h1);
    drive_fields(v);
    i_val = 1'b1;
    for (int a = 0; a < attempts(v.n_err); a++)
      for (int k = 0; k < 5; k++) exp_q.push_back('{dat: v.dw[k], eop: (k == 4)});
    res_q.push_back(v.res_err);
    @(posedge clk); #1;
    i_val = 1'b0;
    chk("first_oval", {63'h0, o_val}, 64'h1);
    chk("first_dw0", {32'h0, o_dat}, {32'h0, v.dw[0]});
    chk("busy_irdy", {63'h0, i_rdy}, 64'h0);
  endtask

  task automatic wait_fis();
    int n = 0;
    while (done_cnt < done_target && n < 500) begin
      @(posedge clk); #1; n++;
    end
    chk("fis_done_timeout", 64'(done_cnt), 64'(done_target));
  endtask

  task automatic do_status(input logic err, input bit last, input logic exp_err,
                           input logic [31:0] dw0, input bit chk0, input logic exp0_err);
    i_stat_val = 1'b1;
    i_stat_err = err;
    @(posedge clk); #1;
    i_stat_val = 1'b0;
    i_stat_err = 1'b0;
    if (last) begin
      chk("res_val_lat", {63'h0, o_res_val}, 64'h1);
      chk("res_err_lat", {63'h0, o_res_err}, {63'h0, exp_err});
    end else begin
      chk("retx_oval", {63'h0, o_val}, 64'h1);
      chk("retx_dw0", {32'h0, o_dat}, {32'h0, dw0});
    end
    if (chk0) begin
      chk("r0_res_val", {63'h0, r0_res_val}, 64'h1);
      chk("r0_res_err", {63'h0, r0_res_err}, {63'h0, exp0_err});
    end
    if (last) begin
      @(posedge clk); #1;
      chk("res_one_cycle", {63'h0, o_res_val}, 64'h0);
      chk("idle_irdy", {63'h0, i_rdy}, 64'h1);
    end
  endtask

  task automatic run_status(input vec_t v, input bit use_r0);
    int att = attempts(v.n_err);
    for (int a = 0; a < att; a++) begin
      done_target++;
      wait_fis();
      do_status(a < v.n_err, a == att - 1, v.res_err, v.dw[0],
                use_r0 && (a == 0), v.n_err > 0);
    end
  endtask

  initial begin
    vec_t v;
    int   rs;
    vecs[0] = mk(8'h25, 16'h0000, 48'h0000_1234_5678, 8'h40, 16'h0008, 8'h00, 0, 0,
                 {32'h0, 32'h0000_0008, 32'h0000_0012, 32'h4034_5678, 32'h0025_8027}, 1'b0);
    vecs[1] = mk(8'h35, 16'hA5C3, 48'hABCD_EF01_2345, 8'hE0, 16'h1234, 8'h08, 2, 1,
                 {32'h0, 32'h0800_1234, 32'hA5AB_CDEF, 32'hE001_2345, 32'hC335_8027}, 1'b0);
    vecs[2] = mk(8'hEC, 16'hFFFF, 48'hFFFF_FFFF_FFFF, 8'hFF, 16'hFFFF, 8'hFF, 9, 0,
                 {32'h0, 32'hFF00_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFEC_8027}, 1'b1);
    vecs[3] = mk(8'hCA, 16'h0100, 48'h0102_0304_0506, 8'h4F, 16'h0080, 8'h00, 3, 1,
                 {32'h0, 32'h0000_0080, 32'h0101_0203, 32'h4F04_0506, 32'h00CA_8027}, 1'b0);

    reset = 1'b1; i_val = 1'b0; o_rdy = 1'b1; i_stat_val = 1'b0; i_stat_err = 1'b0;
    drive_fields(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_irdy", {63'h0, i_rdy}, 64'h1);
    chk("rst_oval", {63'h0, o_val}, 64'h0);
    chk("rst_oeop", {63'h0, o_eop}, 64'h0);
    chk("rst_odat", {32'h0, o_dat}, 64'h0);
    chk("rst_resval", {63'h0, o_res_val}, 64'h0);
    chk("rst_reserr", {63'h0, o_res_err}, 64'h0);
    reset = 1'b0;

    // Table: clean send, two errors then OK, always error, exactly MAXR errors then OK.
    for (int i = 0; i < 4; i++) begin
      rand_bp = vecs[i].bp;
      send_cmd(vecs[i]);
      run_status(vecs[i], 1'b1);
      @(negedge clk);
      rand_bp = 0;
      o_rdy = 1'b1;
    end

    // o_rdy low for three cycles on dw2: dw2 visible for four cycles.
    v = vecs[0];
    send_cmd(v);
    @(posedge clk); #1;
    @(posedge clk); #1;
    o_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_val", {63'h0, o_val}, 64'h1);
      chk("stall_dw2", {32'h0, o_dat}, {32'h0, v.dw[2]});
      chk("stall_eop", {63'h0, o_eop}, 64'h0);
    end
    @(posedge clk); #1;
    o_rdy = 1'b1;
    chk("stall_release_dw2", {32'h0, o_dat}, {32'h0, v.dw[2]});
    run_status(v, 1'b1);

    // New command offered during SEND is ignored, including on the retransmission.
    v = vecs[1];
    v.n_err = 1;
    v.bp = 0;
    send_cmd(v);
    @(posedge clk); #1;
    drive_fields(vecs[2]);
    i_val = 1'b1;
    chk("send_irdy", {63'h0, i_rdy}, 64'h0);
    @(posedge clk); #1;
    i_val = 1'b0;
    run_status(v, 1'b1);

    // Status strobe in the dword-4 cycle is ignored.
    v = vecs[3];
    v.n_err = 0;
    send_cmd(v);
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("dw4_eop", {63'h0, o_eop}, 64'h1);
    i_stat_val = 1'b1;
    i_stat_err = 1'b0;
    rs = res_seen;
    @(posedge clk); #1;
    i_stat_val = 1'b0;
    done_target++;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("early_stat_ignored", 64'(res_seen), 64'(rs));
    chk("wait_oval", {63'h0, o_val}, 64'h0);
    do_status(1'b0, 1'b1, 1'b0, v.dw[0], 1'b0, 1'b0);

    // Reset while dw2 is on the bus; the next command starts from dw0.
    v = vecs[0];
    send_cmd(v);
    @(posedge clk); #1;
    @(posedge clk); #1;
    o_rdy = 1'b0;
    chk("pending_before_reset", 64'(exp_q.size()), 64'd3);
    reset = 1'b1;
    exp_q.delete();
    res_q.delete();
    @(posedge clk); #1;
    chk("midrst_oval", {63'h0, o_val}, 64'h0);
    chk("midrst_oeop", {63'h0, o_eop}, 64'h0);
    chk("midrst_irdy", {63'h0, i_rdy}, 64'h1);
    reset = 1'b0;
    o_rdy = 1'b1;
    v = vecs[1];
    v.n_err = 0;
    v.bp = 0;
    send_cmd(v);
    run_status(v, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("dwords_left", 64'(exp_q.size()), 64'd0);
    chk("results_left", 64'(res_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
